// File: rtl/ws2812b_pkg.sv
// Shared definitions for the WS2812B single-LED driver: FSM states,
// default timing at 27 MHz and counter sizing helper.
package ws2812b_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        LATCH = 2'd2
    } state_t;

    // 27 MHz -> 37.04 ns per cycle: 34 cyc = 1.259 us bit, 11 cyc = 0.407 us,
    // 22 cyc = 0.815 us, 8100 cyc = 300 us latch gap.
    localparam int DEF_BIT_CYCLES   = 34;
    localparam int DEF_T0H_CYCLES   = 11;
    localparam int DEF_T1H_CYCLES   = 22;
    localparam int DEF_RESET_CYCLES = 8100;

    localparam int FRAME_BITS = 24;

    function automatic int cnt_width(input int count, input int min_w);
        int w;
        w = $clog2(count);
        return (w < min_w) ? min_w : w;
    endfunction

endpackage

// File: rtl/ws2812b_bit_encoder.sv
// NRZ pulse-width encoder: turns (bit value, position within bit) into the
// registered line level for the following cycle.
module ws2812b_bit_encoder
    import ws2812b_pkg::*;
#(
    parameter int T0H_CYCLES = DEF_T0H_CYCLES,
    parameter int T1H_CYCLES = DEF_T1H_CYCLES,
    parameter int CNT_W      = 6
) (
    input  logic             Clock,
    input  logic             rst,
    input  logic             i_active,
    input  logic             i_bit,
    input  logic [CNT_W-1:0] i_cnt,
    output logic             o_line
);

    localparam logic [CNT_W-1:0] C_T0H = CNT_W'(T0H_CYCLES);
    localparam logic [CNT_W-1:0] C_T1H = CNT_W'(T1H_CYCLES);

    logic w_line_nxt;
    logic r_line;

    assign w_line_nxt = i_active && (i_cnt < (i_bit ? C_T1H : C_T0H));

    always_ff @(posedge Clock or negedge rst) begin
        if (!rst) begin
            r_line <= 1'b0;
        end else begin
            r_line <= w_line_nxt;
        end
    end

    assign o_line = r_line;

endmodule

// File: rtl/ws2812b.sv
// WS2812B single-LED driver: captures one GRB colour, serialises it MSB first
// and then holds the line low for the latch gap.
module ws2812b
    import ws2812b_pkg::*;
#(
    parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
    parameter int T0H_CYCLES   = DEF_T0H_CYCLES,
    parameter int T1H_CYCLES   = DEF_T1H_CYCLES,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
    input  logic       Clock,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] Red,
    input  logic [7:0] Green,
    input  logic [7:0] Blue,
    output logic       busy,
    output logic       WS2812B_IO,
    output logic [1:0] o_dbg_state
);

    localparam int BIT_W   = cnt_width(BIT_CYCLES, 6);
    localparam int LATCH_W = cnt_width(RESET_CYCLES, 14);

    localparam logic [BIT_W-1:0]   C_BIT_LAST   = BIT_W'(BIT_CYCLES - 1);
    localparam logic [BIT_W-1:0]   C_BIT_ONE    = BIT_W'(1);
    localparam logic [LATCH_W-1:0] C_LATCH_LAST = LATCH_W'(RESET_CYCLES - 1);
    localparam logic [LATCH_W-1:0] C_LATCH_ONE  = LATCH_W'(1);
    localparam logic [4:0]         C_LAST_IDX   = 5'(FRAME_BITS - 1);

    state_t               r_state, w_state_nxt;
    logic [23:0]          r_shift, w_shift_nxt;
    logic [4:0]           r_bit_idx, w_bit_idx_nxt;
    logic [BIT_W-1:0]     r_bit_cnt, w_bit_cnt_nxt;
    logic [LATCH_W-1:0]   r_latch_cnt, w_latch_cnt_nxt;
    logic                 w_enc_active;
    logic                 w_line;

    always_ff @(posedge Clock or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_bit_cnt   <= '0;
            r_latch_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_latch_cnt <= w_latch_cnt_nxt;
        end
    end

    // The current bit is always r_shift[23]; the register shifts left at each
    // bit boundary, so colour inputs are only looked at on the IDLE capture.
    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_bit_idx_nxt   = r_bit_idx;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_latch_cnt_nxt = r_latch_cnt;
        case (r_state)
            IDLE: begin
                if (en) begin
                    w_state_nxt   = SEND;
                    w_shift_nxt   = {Green, Red, Blue};
                    w_bit_idx_nxt = C_LAST_IDX;
                    w_bit_cnt_nxt = '0;
                end
            end
            SEND: begin
                if (r_bit_cnt == C_BIT_LAST) begin
                    w_bit_cnt_nxt = '0;
                    if (r_bit_idx == 5'd0) begin
                        w_state_nxt     = LATCH;
                        w_latch_cnt_nxt = '0;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx - 5'd1;
                        w_shift_nxt   = {r_shift[22:0], 1'b0};
                    end
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + C_BIT_ONE;
                end
            end
            LATCH: begin
                if (r_latch_cnt == C_LATCH_LAST) begin
                    w_state_nxt     = IDLE;
                    w_latch_cnt_nxt = '0;
                end else begin
                    w_latch_cnt_nxt = r_latch_cnt + C_LATCH_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // The encoder is fed next-state values so its flop shows the level for
    // the cycle that the FSM is about to enter.
    assign w_enc_active = (w_state_nxt == SEND);

    ws2812b_bit_encoder #(
        .T0H_CYCLES (T0H_CYCLES),
        .T1H_CYCLES (T1H_CYCLES),
        .CNT_W      (BIT_W)
    ) u_encoder (
        .Clock    (Clock),
        .rst      (rst),
        .i_active (w_enc_active),
        .i_bit    (w_shift_nxt[23]),
        .i_cnt    (w_bit_cnt_nxt),
        .o_line   (w_line)
    );

    assign WS2812B_IO  = w_line;
    assign busy        = (r_state != IDLE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ws2812b.sv
// Bench for ws2812b: measures pulse and busy widths on the pins and checks
// them against frames expected from the colour values.
module tb_ws2812b;
  import ws2812b_pkg::*;

  localparam int BIT_C   = 34;
  localparam int T0H     = 11;
  localparam int T1H     = 22;
  localparam int RESET_C = 8100;
  localparam int BUSY_C  = 24 * BIT_C + RESET_C;
  localparam int PERIOD  = BUSY_C + 1;

  logic       Clock;
  logic       rst;
  logic       en;
  logic [7:0] Red;
  logic [7:0] Green;
  logic [7:0] Blue;
  logic       busy;
  logic       WS2812B_IO;
  logic [1:0] o_dbg_state;

  int checks;
  int failures;
  int unsigned cyc;

  logic [23:0] exp_q[$];
  int          hi_q[$];
  int          lo_q[$];
  int          bhi_q[$];
  int          blo_q[$];
  int unsigned rise_q[$];
  int          hb, bb, rb;

  logic prev_io, prev_busy, have_pulse, have_fall;
  int   hi_run, lo_run, bhi_run, blo_run;

  ws2812b dut (
    .Clock       (Clock),
    .rst         (rst),
    .en          (en),
    .Red         (Red),
    .Green       (Green),
    .Blue        (Blue),
    .busy        (busy),
    .WS2812B_IO  (WS2812B_IO),
    .o_dbg_state (o_dbg_state)
  );

  // clock / reset block
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge Clock);
      cyc++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // pin monitor: run lengths of line and busy, sampled mid-cycle
  initial begin
    prev_io = 1'b0; prev_busy = 1'b0; have_pulse = 1'b0; have_fall = 1'b0;
    hi_run = 0; lo_run = 0; bhi_run = 0; blo_run = 0;
    forever begin
      @(negedge Clock);
      if (WS2812B_IO === 1'b1) begin
        if (!prev_io) begin
          if (have_pulse) lo_q.push_back(lo_run);
          hi_run = 0;
        end
        hi_run++;
      end else begin
        if (prev_io) begin
          hi_q.push_back(hi_run);
          have_pulse = 1'b1;
          lo_run = 0;
        end
        lo_run++;
      end
      prev_io = (WS2812B_IO === 1'b1);
      if (busy === 1'b1) begin
        if (!prev_busy) begin
          rise_q.push_back(cyc);
          if (have_fall) blo_q.push_back(blo_run);
          bhi_run = 0;
        end
        bhi_run++;
      end else begin
        if (prev_busy) begin
          bhi_q.push_back(bhi_run);
          have_fall = 1'b1;
          blo_run = 0;
        end
        blo_run++;
      end
      prev_busy = (busy === 1'b1);
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic mark();
    hb = hi_q.size();
    bb = bhi_q.size();
    rb = rise_q.size();
    exp_q.delete();
  endtask

  task automatic set_colour(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    Red = r; Green = g; Blue = b;
  endtask

  task automatic start_frame(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                             input int en_len, input string name);
    set_colour(r, g, b);
    en = 1'b1;
    @(posedge Clock);
    #1;
    checks++;
    if (busy !== 1'b1 || WS2812B_IO !== 1'b1) begin
      failures++;
      $display("FAIL %s_start: busy=%b io=%b, required busy=1 io=1", name, busy, WS2812B_IO);
    end
    if (en_len > 1) tick(en_len - 1);
    en = 1'b0;
  endtask

  task automatic wait_busy(input logic level, input int budget, input string name);
    int n;
    n = 0;
    do begin
      @(negedge Clock);
      #1;
      n++;
    end while (busy !== level && n < budget);
    checks++;
    if (busy !== level) begin
      failures++;
      $display("FAIL %s_wait: busy=%b after %0d cycles, required %b", name, busy, n, level);
    end
  endtask

  // scoreboard: pulses since mark() against exp_q frames
  task automatic check_frames(input string name, input int gap);
    int n, idx, h, l, e_hi, e_lo, bad_hi, bad_lo;
    logic [23:0] word, got;
    n = exp_q.size();
    checks++;
    if (hi_q.size() - hb != 24 * n) begin
      failures++;
      $display("FAIL %s_pulse_count: got %0d, required %0d", name, hi_q.size() - hb, 24 * n);
    end
    for (int f = 0; f < n; f++) begin
      word = exp_q[f];
      got = '0;
      bad_hi = 0;
      bad_lo = 0;
      for (int b = 0; b < 24; b++) begin
        idx  = hb + 24 * f + b;
        e_hi = word[23 - b] ? T1H : T0H;
        h    = (idx < hi_q.size()) ? hi_q[idx] : -1;
        got  = {got[22:0], (h == T1H)};
        if (h != e_hi) bad_hi++;
        if (b < 23 || f < n - 1) begin
          e_lo = BIT_C - e_hi + ((b == 23) ? (RESET_C + gap) : 0);
          l    = (idx < lo_q.size()) ? lo_q[idx] : -1;
          if (l != e_lo) bad_lo++;
        end
      end
      checks++;
      if (got !== word) begin
        failures++;
        $display("FAIL %s_frame%0d_value: got %06h, required %06h", name, f, got, word);
      end
      checks++;
      if (bad_hi != 0) begin
        failures++;
        $display("FAIL %s_frame%0d_high: %0d bits with wrong high time, required 0", name, f, bad_hi);
      end
      checks++;
      if (bad_lo != 0) begin
        failures++;
        $display("FAIL %s_frame%0d_low: %0d bits with wrong low time, required 0", name, f, bad_lo);
      end
    end
  endtask

  task automatic check_busy(input string name, input int n);
    int bad;
    checks++;
    if (bhi_q.size() - bb != n) begin
      failures++;
      $display("FAIL %s_busy_count: got %0d busy pulses, required %0d", name, bhi_q.size() - bb, n);
    end
    bad = 0;
    for (int i = bb; i < bhi_q.size(); i++) if (bhi_q[i] != BUSY_C) bad++;
    checks++;
    if (bad != 0 || bhi_q.size() == bb) begin
      failures++;
      $display("FAIL %s_busy_width: first width %0d, required %0d", name,
               (bhi_q.size() > bb) ? bhi_q[bb] : -1, BUSY_C);
    end
    if (n > 1) begin
      bad = 0;
      for (int i = rb + 1; i < rise_q.size(); i++) begin
        if (rise_q[i] - rise_q[i-1] != PERIOD) bad++;
        if (blo_q[i-1] != 1) bad++;
      end
      checks++;
      if (bad != 0 || rise_q.size() - rb != n) begin
        failures++;
        $display("FAIL %s_period: %0d bad gaps over %0d starts, required 0 bad gaps over %0d",
                 name, bad, rise_q.size() - rb, n);
      end
    end
  endtask

  task automatic check_latch(input string name, input logic last_bit);
    int e;
    e = BIT_C - (last_bit ? T1H : T0H) + RESET_C + 1;
    checks++;
    if (lo_run != e) begin
      failures++;
      $display("FAIL %s_latch_low: low run %0d at idle, required %0d", name, lo_run, e);
    end
  endtask

  // tests
  task automatic test_reset();
    int k, o;
    rst = 1'b0; en = 1'b0; set_colour(8'h00, 8'h00, 8'h00);
    tick(3);
    checks++;
    if (busy !== 1'b0 || WS2812B_IO !== 1'b0 || o_dbg_state !== 2'(IDLE)) begin
      failures++;
      $display("FAIL reset_values: busy=%b io=%b state=%0d, required 0 0 %0d",
               busy, WS2812B_IO, o_dbg_state, 2'(IDLE));
    end
    rst = 1'b1;
    tick(20);
    checks++;
    if (busy !== 1'b0 || WS2812B_IO !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b io=%b, required 0 0", busy, WS2812B_IO);
    end
    start_frame(8'($urandom), 8'($urandom), 8'($urandom), 1, "reset");
    k = $urandom_range(1, 20);
    o = $urandom_range(0, 9);
    tick(k * BIT_C + o);
    checks++;
    if (busy !== 1'b1 || WS2812B_IO !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre: busy=%b io=%b, required 1 1", busy, WS2812B_IO);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || WS2812B_IO !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: busy=%b io=%b, required 0 0", busy, WS2812B_IO);
    end
    @(posedge Clock);
    #1;
    rst = 1'b1;
    tick(2);
    mark();
    tick(100);
    checks++;
    if (busy !== 1'b0 || hi_q.size() != hb) begin
      failures++;
      $display("FAIL reset_release: busy=%b pulses=%0d, required 0 0", busy, hi_q.size() - hb);
    end
  endtask

  task automatic test_all_ones();
    int n;
    mark();
    exp_q.push_back(24'hFFFFFF);
    start_frame(8'hFF, 8'hFF, 8'hFF, $urandom_range(1, 20), "all_ones");
    n = 0;
    while (busy === 1'b1 && n < 10000) begin
      set_colour(8'($urandom), 8'($urandom), 8'($urandom));
      @(negedge Clock);
      #1;
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL all_ones_wait: busy=%b after %0d cycles, required 0", busy, n);
    end
    check_latch("all_ones", 1'b1);
    check_frames("all_ones", 1);
    check_busy("all_ones", 1);
    tick(1);
  endtask

  task automatic test_bit_order();
    mark();
    exp_q.push_back({8'h80, 8'h01, 8'h00});
    start_frame(8'h01, 8'h80, 8'h00, $urandom_range(1, 20), "bit_order");
    wait_busy(1'b0, 10000, "bit_order");
    check_latch("bit_order", 1'b0);
    check_frames("bit_order", 1);
    check_busy("bit_order", 1);
    tick(1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] r_tab[5];
    logic [7:0] g_tab[5];
    logic [7:0] b_tab[5];
    r_tab = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00};
    g_tab = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00};
    b_tab = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
    mark();
    for (int k = 0; k < 5; k++) exp_q.push_back({g_tab[k], r_tab[k], b_tab[k]});
    set_colour(r_tab[0], g_tab[0], b_tab[0]);
    en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_busy(1'b1, 20, "seq_rise");
      if (k == 4) en = 1'b0;
      wait_busy(1'b0, 10000, "seq_fall");
      if (k < 4) set_colour(r_tab[k+1], g_tab[k+1], b_tab[k+1]);
    end
    check_frames("sequence", 1);
    check_busy("sequence", 5);
    tick(1);
  endtask

  task automatic test_mid_frame();
    mark();
    exp_q.push_back(24'h000000);
    exp_q.push_back(24'hFFFFFF);
    set_colour(8'h00, 8'h00, 8'h00);
    en = 1'b1;
    wait_busy(1'b1, 20, "mid_rise");
    repeat (5 * BIT_C + $urandom_range(0, BIT_C - 1)) @(negedge Clock);
    set_colour(8'hFF, 8'hFF, 8'hFF);
    wait_busy(1'b0, 10000, "mid_fall");
    wait_busy(1'b1, 20, "mid_rise2");
    en = 1'b0;
    wait_busy(1'b0, 10000, "mid_fall2");
    check_frames("mid_frame", 1);
    check_busy("mid_frame", 2);
    tick(1);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_all_ones();
    test_bit_order();
    test_back_to_back();
    test_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
